// File: rtl/shift_arbiter.sv
// Two-requester front end for a shared SLL/SRL/SRA shifter with a registered,
// backpressured response port. Round-robin or fixed-priority grant by RR_EN.
module shift_arbiter #(
  parameter bit         RR_EN  = 1'b1,
  parameter logic [3:0] AluSll = 4'h1,
  parameter logic [3:0] AluSrl = 4'h5,
  parameter logic [3:0] AluSra = 4'hD
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [4:0]  req0_shamt_i,
  input  logic [3:0]  req0_type_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [4:0]  req1_shamt_i,
  input  logic [3:0]  req1_type_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_id_o,
  output logic        busy_o
);

  logic        r_rsp_valid;
  logic [31:0] r_rsp_data;
  logic        r_rsp_id;
  logic        r_last_grant;

  logic        w_can_accept;
  logic        w_grant;
  logic        w_xfer0;
  logic        w_xfer1;
  logic [31:0] w_op_a;
  logic [4:0]  w_op_shamt;
  logic [3:0]  w_op_type;
  logic [31:0] w_shift_res;

  // Response slot is free when empty or being drained on this edge.
  always_comb begin
    w_can_accept = !r_rsp_valid || rsp_ready_i;
    case ({req1_valid_i, req0_valid_i})
      2'b01:   w_grant = 1'b0;
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = RR_EN ? ~r_last_grant : 1'b0;
      default: w_grant = 1'b0;
    endcase
  end

  always_comb begin
    req0_ready_o = rst_n_i && w_can_accept && req0_valid_i && !w_grant;
    req1_ready_o = rst_n_i && w_can_accept && req1_valid_i && w_grant;
    w_xfer0      = req0_valid_i && req0_ready_o;
    w_xfer1      = req1_valid_i && req1_ready_o;
  end

  always_comb begin
    w_op_a     = w_grant ? req1_a_i     : req0_a_i;
    w_op_shamt = w_grant ? req1_shamt_i : req0_shamt_i;
    w_op_type  = w_grant ? req1_type_i  : req0_type_i;
  end

  // Unrecognised op codes still complete the handshake but yield zero.
  always_comb begin
    w_shift_res = 32'h0;
    if (w_op_type == AluSll) begin
      w_shift_res = w_op_a << w_op_shamt;
    end else if (w_op_type == AluSrl) begin
      w_shift_res = w_op_a >> w_op_shamt;
    end else if (w_op_type == AluSra) begin
      w_shift_res = $signed(w_op_a) >>> w_op_shamt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= 32'h0;
      r_rsp_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_xfer0 || w_xfer1) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_data   <= w_shift_res;
      r_rsp_id     <= w_xfer1;
      r_last_grant <= w_xfer1;
    end else if (r_rsp_valid && rsp_ready_i) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;
  assign busy_o      = r_rsp_valid;

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: a round-robin and a fixed-priority instance, each with
// its own requesters, checked against a transaction-level model of the arbiter.
module tb_shift_arbiter;

  localparam logic [3:0] AluSll = 4'h1;
  localparam logic [3:0] AluSrl = 4'h5;
  localparam logic [3:0] AluSra = 4'hD;

  logic        clk;
  logic        rst_n;
  logic        vld     [2][2];
  logic [31:0] op_a    [2][2];
  logic [4:0]  op_sh   [2][2];
  logic [3:0]  op_ty   [2][2];
  logic        rdy0    [2];
  logic        rdy1    [2];
  logic        rsp_rdy [2];
  logic        rsp_vld [2];
  logic [31:0] rsp_dat [2];
  logic        rsp_id  [2];
  logic        busy    [2];

  // Model: contents of the response slot and who was served last.
  logic        m_valid [2];
  logic [31:0] m_data  [2];
  logic        m_id    [2];
  logic        m_last  [2];
  bit          m_known;

  logic        pend    [2][2];
  logic [31:0] prev_a  [2][2];
  logic [4:0]  prev_sh [2][2];
  logic [3:0]  prev_ty [2][2];

  int n_cmp;
  int n_err;

  shift_arbiter #(.RR_EN(1'b1), .AluSll(AluSll), .AluSrl(AluSrl), .AluSra(AluSra)) u_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(vld[0][0]), .req0_ready_o(rdy0[0]), .req0_a_i(op_a[0][0]),
    .req0_shamt_i(op_sh[0][0]), .req0_type_i(op_ty[0][0]),
    .req1_valid_i(vld[0][1]), .req1_ready_o(rdy1[0]), .req1_a_i(op_a[0][1]),
    .req1_shamt_i(op_sh[0][1]), .req1_type_i(op_ty[0][1]),
    .rsp_valid_o(rsp_vld[0]), .rsp_ready_i(rsp_rdy[0]), .rsp_data_o(rsp_dat[0]),
    .rsp_id_o(rsp_id[0]), .busy_o(busy[0])
  );

  shift_arbiter #(.RR_EN(1'b0), .AluSll(AluSll), .AluSrl(AluSrl), .AluSra(AluSra)) u_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_valid_i(vld[1][0]), .req0_ready_o(rdy0[1]), .req0_a_i(op_a[1][0]),
    .req0_shamt_i(op_sh[1][0]), .req0_type_i(op_ty[1][0]),
    .req1_valid_i(vld[1][1]), .req1_ready_o(rdy1[1]), .req1_a_i(op_a[1][1]),
    .req1_shamt_i(op_sh[1][1]), .req1_type_i(op_ty[1][1]),
    .rsp_valid_o(rsp_vld[1]), .rsp_ready_i(rsp_rdy[1]), .rsp_data_o(rsp_dat[1]),
    .rsp_id_o(rsp_id[1]), .busy_o(busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] shift_ref(input logic [31:0] a, input logic [4:0] sh,
                                            input logic [3:0] ty);
    logic [31:0] fill;
    if (ty == AluSll) return a << sh;
    if (ty == AluSrl) return a >> sh;
    if (ty == AluSra) begin
      fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
      return (a >> sh) | fill;
    end
    return 32'h0;
  endfunction

  // Returns {ready1, ready0} the rules demand for instance d (d=0 round-robin).
  function automatic logic [1:0] exp_ready(input int d);
    logic can;
    logic g;
    if (!rst_n) return 2'b00;
    can = !m_valid[d] || rsp_rdy[d];
    if (vld[d][0] && vld[d][1]) g = (d == 0) ? !m_last[d] : 1'b0;
    else                        g = vld[d][1];
    return {can && vld[d][1] && g, can && vld[d][0] && !g};
  endfunction

  task automatic cycle();
    logic [1:0] er [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      er[d] = exp_ready(d);
      check1($sformatf("d%0d_ready0", d), rdy0[d], er[d][0]);
      check1($sformatf("d%0d_ready1", d), rdy1[d], er[d][1]);
      for (int r = 0; r < 2; r++) begin
        if (pend[d][r] && vld[d][r]) begin
          assert (op_a[d][r] == prev_a[d][r] && op_sh[d][r] == prev_sh[d][r] &&
                  op_ty[d][r] == prev_ty[d][r])
            else $error("requester %0d/%0d changed operands while stalled", d, r);
        end
      end
      if (m_known) begin
        check1($sformatf("d%0d_rsp_valid", d), rsp_vld[d], m_valid[d]);
        check1($sformatf("d%0d_busy", d), busy[d], m_valid[d]);
        check32($sformatf("d%0d_rsp_data", d), rsp_dat[d], m_data[d]);
        check1($sformatf("d%0d_rsp_id", d), rsp_id[d], m_id[d]);
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int r = 0; r < 2; r++) begin
        pend[d][r]    = vld[d][r] && !er[d][r];
        prev_a[d][r]  = op_a[d][r];
        prev_sh[d][r] = op_sh[d][r];
        prev_ty[d][r] = op_ty[d][r];
      end
      if (!rst_n) begin
        m_valid[d] = 1'b0;
        m_data[d]  = 32'h0;
        m_id[d]    = 1'b0;
        m_last[d]  = 1'b1;
      end else if (er[d][0] || er[d][1]) begin
        m_data[d]  = er[d][1] ? shift_ref(op_a[d][1], op_sh[d][1], op_ty[d][1])
                              : shift_ref(op_a[d][0], op_sh[d][0], op_ty[d][0]);
        m_id[d]    = er[d][1];
        m_last[d]  = er[d][1];
        m_valid[d] = 1'b1;
      end else if (m_valid[d] && rsp_rdy[d]) begin
        m_valid[d] = 1'b0;
      end
    end
    if (!rst_n) m_known = 1'b1;
    #1;
  endtask

  task automatic drv(input int r, input logic v, input logic [31:0] a, input logic [4:0] sh,
                     input logic [3:0] ty);
    for (int d = 0; d < 2; d++) begin
      vld[d][r]   = v;
      op_a[d][r]  = a;
      op_sh[d][r] = sh;
      op_ty[d][r] = ty;
    end
  endtask

  task automatic set_rsp_ready(input logic v);
    rsp_rdy[0] = v;
    rsp_rdy[1] = v;
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    m_known = 1'b0;
    rst_n   = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0;
      m_data[d]  = 32'h0;
      m_id[d]    = 1'b0;
      m_last[d]  = 1'b1;
      for (int r = 0; r < 2; r++) pend[d][r] = 1'b0;
    end
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);
    drv(1, 1'b0, 32'h0, 5'd0, AluSll);
    set_rsp_ready(1'b1);
    #1;
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      check1($sformatf("d%0d_reset_valid", d), rsp_vld[d], 1'b0);
      check32($sformatf("d%0d_reset_data", d), rsp_dat[d], 32'h0);
    end

    // Single requester 0, SLL.
    drv(0, 1'b1, 32'h0000_00F0, 5'd4, AluSll);
    #1 check1("sll_ready0_same_cycle", rdy0[0], 1'b1);
    cycle();
    check1("sll_rsp_valid", rsp_vld[0], 1'b1);
    check32("sll_rsp_data", rsp_dat[0], 32'h0000_0F00);
    check1("sll_rsp_id", rsp_id[0], 1'b0);
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);

    // Single requester 1, SRA then SRL of the sign bit.
    drv(1, 1'b1, 32'h8000_0000, 5'd31, AluSra);
    cycle();
    check32("sra_rsp_data", rsp_dat[0], 32'hFFFF_FFFF);
    check1("sra_rsp_id", rsp_id[0], 1'b1);
    drv(1, 1'b1, 32'h8000_0000, 5'd31, AluSrl);
    cycle();
    check32("srl_rsp_data", rsp_dat[1], 32'h0000_0001);
    drv(1, 1'b0, 32'h0, 5'd0, AluSll);
    cycle();

    // Both requesters streaming: alternation vs fixed priority.
    drv(0, 1'b1, 32'h0000_0003, 5'd1, AluSll);
    drv(1, 1'b1, 32'h0000_0100, 5'd2, AluSrl);
    for (int i = 0; i < 4; i++) begin
      #1 check1($sformatf("fp_ready1_low_%0d", i), rdy1[1], 1'b0);
      cycle();
      check1($sformatf("rr_id_seq_%0d", i), rsp_id[0], i[0]);
      check1($sformatf("fp_id_seq_%0d", i), rsp_id[1], 1'b0);
    end
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);
    drv(1, 1'b0, 32'h0, 5'd0, AluSll);
    cycle();

    // Backpressure with both valid, then drain and accept on the same edge.
    set_rsp_ready(1'b0);
    drv(0, 1'b1, 32'h1234_5678, 5'd8, AluSrl);
    cycle();
    drv(1, 1'b1, 32'h0000_0F0F, 5'd4, AluSll);
    for (int i = 0; i < 3; i++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        check1($sformatf("bp_ready0_d%0d_%0d", d, i), rdy0[d], 1'b0);
        check1($sformatf("bp_ready1_d%0d_%0d", d, i), rdy1[d], 1'b0);
      end
      cycle();
      check32($sformatf("bp_hold_data_%0d", i), rsp_dat[0], 32'h0012_3456);
    end
    set_rsp_ready(1'b1);
    #1 check1("bp_release_rr_ready1", rdy1[0], 1'b1);
    check1("bp_release_fp_ready0", rdy0[1], 1'b1);
    cycle();
    check1("bp_overlap_valid", rsp_vld[0], 1'b1);
    check32("bp_overlap_data", rsp_dat[0], 32'h0000_F0F0);
    check1("bp_overlap_rr_id", rsp_id[0], 1'b1);
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);
    drv(1, 1'b0, 32'h0, 5'd0, AluSll);
    cycle();

    // Illegal op code and zero shift.
    drv(0, 1'b1, 32'hDEAD_BEEF, 5'd3, 4'hF);
    cycle();
    check1("illegal_valid", rsp_vld[0], 1'b1);
    check32("illegal_data", rsp_dat[0], 32'h0);
    drv(0, 1'b1, 32'hDEAD_BEEF, 5'd0, AluSll);
    cycle();
    check32("shamt0_data", rsp_dat[0], 32'hDEAD_BEEF);
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);
    cycle();

    // Reset while a response is held under backpressure.
    set_rsp_ready(1'b0);
    drv(0, 1'b1, 32'hA5A5_0000, 5'd4, AluSll);
    cycle();
    drv(1, 1'b1, 32'h0000_00FF, 5'd1, AluSra);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check1($sformatf("rst_ready0_d%0d", d), rdy0[d], 1'b0);
      check1($sformatf("rst_ready1_d%0d", d), rdy1[d], 1'b0);
    end
    cycle();
    check1("rst_rsp_valid", rsp_vld[0], 1'b0);
    check32("rst_rsp_data", rsp_dat[0], 32'h0);
    check1("rst_rsp_id", rsp_id[0], 1'b0);
    rst_n = 1'b1;
    #1 check1("post_rst_rr_ready0", rdy0[0], 1'b1);
    check1("post_rst_rr_ready1", rdy1[0], 1'b0);
    set_rsp_ready(1'b1);
    cycle();
    check1("post_rst_rr_id", rsp_id[0], 1'b0);
    drv(0, 1'b0, 32'h0, 5'd0, AluSll);
    drv(1, 1'b0, 32'h0, 5'd0, AluSll);
    cycle();

    // Randomised traffic, operands held while stalled.
    for (int i = 0; i < 2000; i++) begin
      for (int d = 0; d < 2; d++) begin
        rsp_rdy[d] = ($urandom_range(0, 9) < 7);
        for (int r = 0; r < 2; r++) begin
          if (!(pend[d][r] && vld[d][r])) begin
            vld[d][r]   = $urandom_range(0, 1) == 1;
            op_a[d][r]  = $urandom;
            op_sh[d][r] = 5'($urandom);
            case ($urandom_range(0, 3))
              0:       op_ty[d][r] = AluSll;
              1:       op_ty[d][r] = AluSrl;
              2:       op_ty[d][r] = AluSra;
              default: op_ty[d][r] = 4'($urandom);
            endcase
          end
        end
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one shifter instance (SLL/SRL/SRA on 32-bit data, 5-bit shift amount, 4-bit ALU op code from defines.v) between two requesters.
- Typical requesters: the execute-stage shift path and a multi-cycle helper unit, e.g. a future mul/div sequencer.
- Interfaces: valid/ready on both request sides; one registered response port with backpressure.
- Arbitration: round-robin, or fixed priority by parameter.

Parameters:
- RR_EN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins.

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_n_i  input  1  reset, synchronous, active-low
- req0_valid_i  input  1  requester 0 has an operation
- req0_ready_o  output  1  requester 0 operation accepted this cycle
- req0_a_i  input  32  requester 0 operand
- req0_shamt_i  input  5  requester 0 shift amount
- req0_type_i  input  4  requester 0 op code (ALU_SLL/ALU_SRL/ALU_SRA; others legal)
- req1_valid_i  input  1  requester 1 has an operation
- req1_ready_o  output  1  requester 1 operation accepted this cycle
- req1_a_i  input  32  requester 1 operand
- req1_shamt_i  input  5  requester 1 shift amount
- req1_type_i  input  4  requester 1 op code
- rsp_valid_o  output  1  response register holds a result
- rsp_ready_i  input  1  consumer takes the result this cycle
- rsp_data_o  output  32  shift result
- rsp_id_o  output  1  requester that owns rsp_data_o
- busy_o  output  1  equals rsp_valid_o

Behaviour:
- Reset:
  - Reset is sampled only at the clock edge while rst_n_i = 0.
  - Register values under reset: rsp_valid_o = 0, rsp_data_o = 0, rsp_id_o = 0, last_grant = 1, so requester 0 wins the first contest.
  - Both readies are forced 0 while rst_n_i = 0.
  - Reset mid-operation discards any held response without handshake.
- Accept condition:
  - can_accept = !rsp_valid_o | rsp_ready_i. The response register is empty, or it is draining this cycle.
  - This gives full throughput: one operation per cycle when rsp_ready_i stays high.
- Grant (combinational, at most one ready high per cycle):
  - Only one valid high: that requester is granted.
  - Both valid, RR_EN=1: grant the requester that is not last_grant.
  - Both valid, RR_EN=0: grant requester 0.
  - reqX_ready_o = can_accept & reqX_valid_i & grant==X.
  - Ready may depend on valid. Requesters must not make valid depend on ready.
- Transfer and update:
  - A transfer occurs when reqX_valid_i & reqX_ready_o.
  - On the transfer edge, the shifter is driven by the granted operand mux.
  - rsp_data_o <= shifter result; rsp_id_o <= X; rsp_valid_o <= 1; last_grant <= X.
  - Latency: exactly 1 cycle from accept edge to rsp_valid_o high.
- Drain: rsp_valid_o & rsp_ready_i with no new transfer -> rsp_valid_o <= 0. rsp_data_o and rsp_id_o hold their last values.
- Simultaneous drain and accept: the new result overwrites in the same edge and rsp_valid_o stays 1.
- Backpressure:
  - While rsp_valid_o & !rsp_ready_i, both readies are 0.
  - rsp_data_o and rsp_id_o stay stable until the handshake completes.
- Requester stability: a requester holding valid without ready must keep a, shamt and type stable. The bench asserts this; the RTL does not check it.
- Op semantics (delegated to the shifter):
  - ALU_SLL: logical left shift.
  - ALU_SRL: logical right shift.
  - ALU_SRA: arithmetic right shift, sign-filling from bit 31.
  - Any other type code: result 0, still handshaked normally.
  - shamt = 0 returns the operand unchanged.
- Fairness: with RR_EN=1 and both valid continuously, grants alternate 0,1,0,1. No requester waits more than one transfer.
- Idle: no valid asserted -> no state change except draining.

Test Plan:
- Reset then req0 only, a=0x0000_00F0, shamt=4, SLL, rsp_ready_i=1 -> req0_ready_o=1 same cycle; next cycle rsp_valid_o=1, rsp_data_o=0x0000_0F00, rsp_id_o=0.
- req1 only, a=0x8000_0000, shamt=31, SRA -> rsp_data_o=0xFFFF_FFFF, id=1. Same operand with SRL -> 0x0000_0001.
- Both valid for 4 cycles, RR_EN=1, rsp_ready_i=1 -> grants 0,1,0,1; rsp_id_o sequence 0,1,0,1 on consecutive cycles. With RR_EN=0 -> four grants to 0 and req1_ready_o stays 0.
- Backpressure:
  - Fill with req0 (a=0x1234_5678, shamt=8, SRL) and hold rsp_ready_i=0 for 3 cycles with both valid.
  - Required: both readies 0; rsp_data_o stays 0x0012_3456.
  - Then raise rsp_ready_i -> drain and new accept on the same edge; rsp_valid_o stays 1.
- Illegal type 4'hF with a=0xDEAD_BEEF -> accepted, rsp_data_o=0. shamt=0 SLL on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Assert rst_n_i=0 for one edge while rsp_valid_o=1 and rsp_ready_i=0:
  - Required: rsp_valid_o=0, rsp_data_o=0, readies 0 during reset.
  - After release with both valid: first grant goes to req0.
